// File: rtl/key_event_arbiter.sv
// Debounces NUM_KEYS keys with one shared tick and queues {key, polarity} edge events in a FWFT FIFO.
// Latency: the first event of tick T is visible at cycle T+3; later events of that scan follow one per cycle.
// Backpressure: a push into a full FIFO is dropped and sets sticky OVERFLOW, unless a pop happens in the same cycle.
module key_event_arbiter #(
    parameter int                  NUM_KEYS      = 8,
    parameter logic [31:0]         TICK_PERIOD   = 32'd999999,
    parameter int                  FIFO_DEPTH    = 4,
    parameter logic [NUM_KEYS-1:0] INITIAL_STATE = {NUM_KEYS{1'b0}},
    localparam int                 KW            = $clog2(NUM_KEYS)
) (
    input  logic                CLK_O,
    input  logic                XRST,
    input  logic [NUM_KEYS-1:0] KEY_I,
    output logic [NUM_KEYS-1:0] KEY_STATE,
    output logic                EVT_VALID,
    input  logic                EVT_READY,
    output logic [KW-1:0]       EVT_KEY,
    output logic                EVT_POS,
    output logic                OVERFLOW,
    input  logic                CLR_OVF
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [KW-1:0] key;
        logic          pos;
    } evt_t;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] ff0_q, ff1_q;
    logic [31:0]         cnt_q;
    logic                tick;

    state_t              state_q;
    logic [NUM_KEYS-1:0] pend_q, pol_q, pend_d;
    logic [KW-1:0]       scan_idx;

    evt_t                mem_q [FIFO_DEPTH];
    logic [AW:0]         wr_ptr_q, rd_ptr_q;
    logic                ovf_q;
    logic                fifo_empty, fifo_full, pop, push_vld, push_ok, drop;
    evt_t                push_dat, head;

    assign tick = (cnt_q == TICK_PERIOD);

    always_ff @(posedge CLK_O or negedge XRST) begin
        if (!XRST) begin
            sync1_q <= INITIAL_STATE;
            sync2_q <= INITIAL_STATE;
            ff0_q   <= INITIAL_STATE;
            ff1_q   <= INITIAL_STATE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= KEY_I;
            sync2_q <= sync1_q;
            cnt_q   <= tick ? '0 : cnt_q + 32'd1;
            if (tick) begin
                ff0_q <= sync2_q;
                ff1_q <= ff0_q;
            end
        end
    end

    assign KEY_STATE = ff0_q;

    // Lowest pending key wins; the scan visits keys in ascending index order.
    always_comb begin
        scan_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pend_q[i]) scan_idx = KW'(i);
        end
        pend_d = pend_q & ~({{(NUM_KEYS-1){1'b0}}, 1'b1} << scan_idx);
    end

    always_ff @(posedge CLK_O or negedge XRST) begin
        if (!XRST) begin
            state_q <= IDLE;
            pend_q  <= '0;
            pol_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (tick) state_q <= LOAD;
                LOAD: begin
                    pend_q  <= ff0_q ^ ff1_q;
                    pol_q   <= ff0_q;
                    state_q <= ((ff0_q ^ ff1_q) == '0) ? IDLE : SCAN;
                end
                SCAN: begin
                    pend_q <= pend_d;
                    if (pend_d == '0) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign push_vld     = (state_q == SCAN);
    assign push_dat.key = scan_idx;
    assign push_dat.pos = pol_q[scan_idx];

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && EVT_READY;
    // A simultaneous pop frees the slot the push needs.
    assign push_ok    = push_vld && (!fifo_full || pop);
    assign drop       = push_vld && fifo_full && !pop;

    always_ff @(posedge CLK_O) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end

    always_ff @(posedge CLK_O or negedge XRST) begin
        if (!XRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop)         ovf_q <= 1'b1;
            else if (CLR_OVF) ovf_q <= 1'b0;
        end
    end

    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign EVT_VALID = !fifo_empty;
    assign EVT_KEY   = EVT_VALID ? head.key : '0;
    assign EVT_POS   = EVT_VALID ? head.pos : 1'b0;
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed scenarios plus randomized traffic against a tick-level event-queue model.
module tb_key_event_arbiter;

    logic       CLK_O = 1'b0;
    logic       XRST = 1'b0;
    logic [3:0] KEY_I = 4'h0;
    logic [3:0] KEY_STATE;
    logic       EVT_VALID;
    logic       EVT_READY = 1'b0;
    logic [1:0] EVT_KEY;
    logic       EVT_POS;
    logic       OVERFLOW;
    logic       CLR_OVF = 1'b0;

    int vectors = 0;
    int errors  = 0;

    key_event_arbiter #(
        .NUM_KEYS(4), .TICK_PERIOD(32'd15), .FIFO_DEPTH(4), .INITIAL_STATE(4'h0)
    ) dut (
        .CLK_O(CLK_O), .XRST(XRST), .KEY_I(KEY_I), .KEY_STATE(KEY_STATE),
        .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_KEY(EVT_KEY),
        .EVT_POS(EVT_POS), .OVERFLOW(OVERFLOW), .CLR_OVF(CLR_OVF)
    );

    always #5 CLK_O = ~CLK_O;

    // Model: a tick every 16 cycles samples the keys; each changed key (ascending) is
    // scheduled to enter a 4-deep queue at the end of cycle T+2+k.
    typedef struct packed {logic [1:0] key; logic pos;} ev_t;
    typedef struct {int cyc; ev_t ev;} sch_t;
    ev_t        mq[$];
    sch_t       sq[$];
    int         m_n = 0;
    logic [3:0] m_state = 4'h0;
    logic       m_ovf = 1'b0;

    task automatic model_step();
        logic pop, have, drop;
        int   k;
        sch_t s;
        if (!XRST) begin
            mq.delete(); sq.delete();
            m_n = 0; m_state = 4'h0; m_ovf = 1'b0;
        end else begin
            pop  = (mq.size() > 0) && EVT_READY;
            have = (sq.size() > 0) && (sq[0].cyc == m_n);
            drop = have && (mq.size() == 4) && !pop;
            if (pop) void'(mq.pop_front());
            if (have) begin
                s = sq.pop_front();
                if (!drop) mq.push_back(s.ev);
            end
            if (drop) m_ovf = 1'b1;
            else if (CLR_OVF) m_ovf = 1'b0;
            if (m_n % 16 == 15) begin
                k = 0;
                for (int i = 0; i < 4; i++) begin
                    if (KEY_I[i] != m_state[i]) begin
                        s.cyc = m_n + 2 + k; s.ev.key = 2'(i); s.ev.pos = KEY_I[i];
                        sq.push_back(s);
                        k++;
                    end
                end
                m_state = KEY_I;
            end
            m_n++;
        end
    endtask

    always @(posedge CLK_O or negedge XRST) model_step();

    task automatic wait_cyc(input int c);
        while (m_n < c) @(negedge CLK_O);
    endtask

    task automatic reset_dut();
        @(negedge CLK_O);
        XRST = 1'b0; KEY_I = 4'h0; EVT_READY = 1'b0; CLR_OVF = 1'b0;
        repeat (3) @(negedge CLK_O);
        XRST = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK_O);
        XRST = 1'b0;
        #1;
        vectors++;
        if ({EVT_VALID, EVT_KEY, EVT_POS, OVERFLOW, KEY_STATE} !== 9'b0) begin
            errors++;
            $display("FAIL reset_values: got v=%b k=%0d p=%b ovf=%b ks=%h, want all 0",
                     EVT_VALID, EVT_KEY, EVT_POS, OVERFLOW, KEY_STATE);
        end
        reset_dut();
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK_O);
            vectors++;
            if ({EVT_VALID, OVERFLOW, KEY_STATE} !== 6'b0) begin
                errors++;
                $display("FAIL idle_quiet c=%0d: got v=%b ovf=%b ks=%h, want 0/0/0",
                         c, EVT_VALID, OVERFLOW, KEY_STATE);
            end
        end
    endtask

    task automatic test_chatter();
        int       nvalid = 0;
        logic [2:0] got = 3'b0;
        reset_dut();
        EVT_READY = 1'b1;
        for (int c = 16; c <= 160; c++) begin
            wait_cyc(c);
            if (EVT_VALID) begin
                nvalid++;
                got = {EVT_KEY, EVT_POS};
            end
            if (c == 48) begin
                vectors++;
                if (KEY_STATE !== 4'h4) begin
                    errors++;
                    $display("FAIL chatter_state: got %h, want 4", KEY_STATE);
                end
            end
            if (c == 16 || c == 19 || c == 22 || c == 25 || c == 28) KEY_I[2] = ~KEY_I[2];
        end
        vectors++;
        if (nvalid != 1 || got !== 3'b101) begin
            errors++;
            $display("FAIL chatter_events: got %0d events last={%0d,%b}, want 1 event {2,1}",
                     nvalid, got[2:1], got[0]);
        end
    endtask

    task automatic test_scan_order();
        logic       exp_v [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] exp_e [5] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b000};
        reset_dut();
        EVT_READY = 1'b1;
        wait_cyc(5);
        KEY_I = 4'b1011;
        for (int j = 0; j < 5; j++) begin
            wait_cyc(17 + j);
            vectors++;
            if (EVT_VALID !== exp_v[j] || (exp_v[j] && {EVT_KEY, EVT_POS} !== exp_e[j])) begin
                errors++;
                $display("FAIL scan_order cyc=T+%0d: got v=%b {%0d,%b}, want v=%b {%0d,%b}",
                         j + 2, EVT_VALID, EVT_KEY, EVT_POS, exp_v[j], exp_e[j][2:1], exp_e[j][0]);
            end
        end
        vectors++;
        if (KEY_STATE !== 4'hB) begin
            errors++;
            $display("FAIL scan_state: got %h, want b", KEY_STATE);
        end
    endtask

    task automatic test_overflow();
        reset_dut();
        wait_cyc(2);  KEY_I = 4'hF;
        wait_cyc(21); KEY_I = 4'h0;
        wait_cyc(40);
        for (int j = 0; j < 5; j++) begin
            wait_cyc(40 + j);
            vectors++;
            if (j < 4) begin
                if (!EVT_VALID || {EVT_KEY, EVT_POS} !== {2'(j), 1'b1} || OVERFLOW !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_drain j=%0d: got v=%b {%0d,%b} ovf=%b, want v=1 {%0d,1} ovf=1",
                             j, EVT_VALID, EVT_KEY, EVT_POS, OVERFLOW, j);
                end
            end else if (EVT_VALID !== 1'b0) begin
                errors++;
                $display("FAIL ovf_empty: got v=%b, want 0", EVT_VALID);
            end
            EVT_READY = (j < 4);
        end
        wait_cyc(45);
        vectors++;
        if (OVERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b, want 1", OVERFLOW);
        end
        CLR_OVF = 1'b1;
        wait_cyc(46); CLR_OVF = 1'b0;
        wait_cyc(47);
        vectors++;
        if (OVERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b, want 0", OVERFLOW);
        end
    endtask

    task automatic test_full_pop();
        logic [2:0] exp_e [4] = '{3'b011, 3'b101, 3'b111, 3'b000};
        reset_dut();
        wait_cyc(2);  KEY_I = 4'hF;
        wait_cyc(21); KEY_I = 4'b1110;
        wait_cyc(33); EVT_READY = 1'b1;
        wait_cyc(34); EVT_READY = 1'b0;
        for (int j = 0; j < 5; j++) begin
            wait_cyc(34 + j);
            vectors++;
            if (j < 4) begin
                if (!EVT_VALID || {EVT_KEY, EVT_POS} !== exp_e[j] || OVERFLOW !== 1'b0) begin
                    errors++;
                    $display("FAIL full_pop j=%0d: got v=%b {%0d,%b} ovf=%b, want v=1 {%0d,%b} ovf=0",
                             j, EVT_VALID, EVT_KEY, EVT_POS, OVERFLOW, exp_e[j][2:1], exp_e[j][0]);
                end
            end else if (EVT_VALID !== 1'b0 || OVERFLOW !== 1'b0) begin
                errors++;
                $display("FAIL full_pop_end: got v=%b ovf=%b, want 0/0", EVT_VALID, OVERFLOW);
            end
            EVT_READY = 1'b1;
        end
        EVT_READY = 1'b0;
    endtask

    task automatic test_reset_midscan();
        int nvalid = 0;
        reset_dut();
        wait_cyc(5); KEY_I = 4'b0111;
        wait_cyc(18);
        vectors++;
        if (EVT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL midscan_pre: got v=%b, want 1", EVT_VALID);
        end
        XRST = 1'b0;
        KEY_I = 4'h0;
        #1;
        vectors++;
        if (EVT_VALID !== 1'b0 || OVERFLOW !== 1'b0 || KEY_STATE !== 4'h0) begin
            errors++;
            $display("FAIL midscan_reset: got v=%b ovf=%b ks=%h, want 0/0/0", EVT_VALID, OVERFLOW, KEY_STATE);
        end
        repeat (2) @(negedge CLK_O);
        XRST = 1'b1;
        EVT_READY = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK_O);
            if (EVT_VALID) nvalid++;
        end
        vectors++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL midscan_after: got %0d valid cycles, want 0", nvalid);
        end
    endtask

    task automatic test_random();
        logic [8:0] obs, exp;
        logic       ev;
        int         bias;
        reset_dut();
        for (int p = 0; p < 40; p++) begin
            bias = $urandom_range(0, 4);
            for (int c = 0; c < 16; c++) begin
                @(negedge CLK_O);
                ev  = (mq.size() > 0);
                obs = {EVT_VALID, EVT_VALID ? {EVT_KEY, EVT_POS} : 3'b0, OVERFLOW, KEY_STATE};
                exp = {ev, ev ? mq[0] : 3'b0, m_ovf, m_state};
                vectors++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL random cyc=%0d: got v/k/p/ovf/ks=%b, want %b", m_n, obs, exp);
                end
                EVT_READY = ($urandom_range(0, 3) < bias);
                CLR_OVF   = ($urandom_range(0, 15) == 0);
                if ((m_n % 16) <= 12 && $urandom_range(0, 5) == 0) KEY_I = 4'($urandom);
            end
        end
        EVT_READY = 1'b0;
        CLR_OVF   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_chatter();
        test_scan_order();
        test_overflow();
        test_full_pop();
        test_reset_midscan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
